// File: rtl/sync_fifo_prog.sv
// Synchronous first-word-fall-through FIFO with programmable almost-full and almost-empty thresholds.
// It also provides sticky overflow/underflow flags and a high-water mark.
module sync_fifo_prog #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  input  logic             flush,
  input  logic [CNT_W-1:0] af_thresh,
  input  logic [CNT_W-1:0] ae_thresh,
  input  logic             err_clr,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow,
  output logic [CNT_W-1:0] max_level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             pop_acc;
  logic             push_acc;
  logic             ovf_evt;
  logic             unf_evt;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] max_nxt;

  // flush swallows both requests in its cycle, so it also suppresses error events
  always_comb begin
    pop_acc  = pop && (count != '0) && !flush;
    push_acc = push && ((count != FULL_CNT) || pop_acc) && !flush;
    ovf_evt  = push && !flush && !push_acc;
    unf_evt  = pop && !flush && (count == '0);
  end

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (push_acc && !pop_acc)
      count_nxt = count + CNT_W'(1);
    else if (pop_acc && !push_acc)
      count_nxt = count - CNT_W'(1);
  end

  // a fresh clear still records the level this edge establishes
  always_comb begin
    max_nxt = max_level;
    if (err_clr)
      max_nxt = count_nxt;
    else if (count_nxt > max_level)
      max_nxt = count_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      max_level <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_acc)
          wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
        if (pop_acc)
          rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      count     <= count_nxt;
      overflow  <= ovf_evt || (overflow && !err_clr);
      underflow <= unf_evt || (underflow && !err_clr);
      max_level <= max_nxt;
    end
  end

  // storage is never reset; visibility is gated by count
  always_ff @(posedge clk) begin
    if (push_acc)
      mem[wr_ptr] <= wr_data;
  end

  always_comb begin
    rd_data      = (count != '0) ? mem[rd_ptr] : '0;
    full         = (count == FULL_CNT);
    empty        = (count == '0);
    almost_full  = (count >= af_thresh);
    almost_empty = (count <= ae_thresh);
  end

endmodule
